fifo_ptr_ctrl: RTL and testbench

Parametrised read/write pointer controller for the FIFO, generalising the single clear/increment memory pointer to a full pointer pair.
- Holds independent write and read pointers with modulo-DEPTH wrap, so DEPTH need not be a power of two.
- Keeps an occupancy count and registered full, empty, almost_full and almost_empty flags.
- Gates requests so the memory is never written when full or read when empty, and records overflow and underflow attempts in sticky bits.
- Sits between the FIFO control logic and the dual-port storage array; it holds no data.

---
 rtl/fifo_ptr_ctrl_pkg.sv | 42 ++++
 rtl/fifo_ptr_ctrl_if.sv | 40 ++++
 rtl/wrap_ptr.sv | 38 +++
 rtl/fifo_ptr_ctrl.sv | 103 ++++++++++
 tb/tb_fifo_ptr_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/fifo_ptr_ctrl_pkg.sv
// Shared constants, flag/error record types and the pointer-width helper for fifo_ptr_ctrl.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package fifo_ptr_ctrl_pkg;

  localparam int DEF_DEPTH        = 16;
  localparam int DEF_AFULL_MARGIN = 2;
  localparam int DEF_AEMPTY_TH    = 2;

  // Registered status flags, kept together so clear/reset load one constant.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } flags_t;

  // Sticky error record.
  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_t;

  // An empty FIFO reports empty and almost_empty; everything else is low.
  localparam flags_t FLAGS_RST = '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
  localparam err_t   ERR_RST   = '{overflow: 1'b0, underflow: 1'b0};

  // Bits needed to address 0..v-1; at least one bit.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl_if.sv
// Request/acceptance/status bundle between FIFO control logic and the pointer controller.
// Latency: none (wires only).
// Backpressure: wr_en/rd_en tell the requester whether its request was taken this cycle.
interface fifo_ptr_ctrl_if
  import fifo_ptr_ctrl_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
);
  localparam int AW = clog2(DEPTH);

  logic          clr_ptr;
  logic          wr_req;
  logic          rd_req;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  // FIFO control logic side: issues requests, observes acceptance and status.
  modport master (
    output clr_ptr, wr_req, rd_req,
    input  wr_en, rd_en, wr_ptr, rd_ptr, count,
    input  full, empty, almost_full, almost_empty, overflow, underflow
  );

  // Pointer controller side.
  modport slave (
    input  clr_ptr, wr_req, rd_req,
    output wr_en, rd_en, wr_ptr, rd_ptr, count,
    output full, empty, almost_full, almost_empty, overflow, underflow
  );

endinterface

// File: rtl/wrap_ptr.sv
// Modulo-DEPTH pointer with synchronous clear; DEPTH need not be a power of two.
// Latency: new value visible the cycle after inc_ptr.
// Backpressure: none; caller gates inc_ptr.
module wrap_ptr
  import fifo_ptr_ctrl_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic          ck,
  input  logic          reset_n,
  input  logic          clr_ptr,
  input  logic          inc_ptr,
  output logic [AW-1:0] ptr
);

  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  // Next pointer: clear wins, otherwise step and wrap at DEPTH-1.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_ptr) begin
      ptr_d = '0;
    end else if (inc_ptr) begin
      ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge ck or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointer pair, occupancy count, status flags and sticky error bits for a FIFO.
// Latency: wr_en/rd_en combinational; pointers, count and flags update on the next edge.
// Backpressure: writes refused while full, reads refused while empty, all refused during clr_ptr.
module fifo_ptr_ctrl
  import fifo_ptr_ctrl_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_TH  = DEPTH - DEF_AFULL_MARGIN,
  parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
  input  logic           ck,
  input  logic           reset_n,
  fifo_ptr_ctrl_if.slave bus
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  flags_t        flags_q;
  flags_t        flags_d;
  err_t          err_q;
  err_t          err_d;

  // Acceptance uses the registered flags, so it never depends on this cycle's outcome.
  assign wr_en = bus.wr_req & ~flags_q.full  & ~bus.clr_ptr;
  assign rd_en = bus.rd_req & ~flags_q.empty & ~bus.clr_ptr;

  wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .ck      (ck),
    .reset_n (reset_n),
    .clr_ptr (bus.clr_ptr),
    .inc_ptr (wr_en),
    .ptr     (wr_ptr)
  );

  wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .ck      (ck),
    .reset_n (reset_n),
    .clr_ptr (bus.clr_ptr),
    .inc_ptr (rd_en),
    .ptr     (rd_ptr)
  );

  // Next count and flags; flags come from the next count so they line up with it.
  always_comb begin
    count_d = count_q;
    flags_d = flags_q;
    if (bus.clr_ptr) begin
      count_d = '0;
      flags_d = FLAGS_RST;
    end else begin
      if (wr_en && !rd_en)      count_d = count_q + CW'(1);
      else if (rd_en && !wr_en) count_d = count_q - CW'(1);
      flags_d.full         = (count_d == CW'(DEPTH));
      flags_d.empty        = (count_d == '0);
      flags_d.almost_full  = (count_d >= CW'(AFULL_TH));
      flags_d.almost_empty = (count_d <= CW'(AEMPTY_TH));
    end
  end

  // Sticky errors: any refused request against full/empty sets them until cleared.
  always_comb begin
    err_d = err_q;
    if (bus.clr_ptr) begin
      err_d = ERR_RST;
    end else begin
      if (bus.wr_req && flags_q.full)  err_d.overflow  = 1'b1;
      if (bus.rd_req && flags_q.empty) err_d.underflow = 1'b1;
    end
  end

  // Count, flag and error registers.
  always_ff @(posedge ck or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      flags_q <= FLAGS_RST;
      err_q   <= ERR_RST;
    end else begin
      count_q <= count_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign bus.wr_en        = wr_en;
  assign bus.rd_en        = rd_en;
  assign bus.wr_ptr       = wr_ptr;
  assign bus.rd_ptr       = rd_ptr;
  assign bus.count        = count_q;
  assign bus.full         = flags_q.full;
  assign bus.empty        = flags_q.empty;
  assign bus.almost_full  = flags_q.almost_full;
  assign bus.almost_empty = flags_q.almost_empty;
  assign bus.overflow     = err_q.overflow;
  assign bus.underflow    = err_q.underflow;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed bench for fifo_ptr_ctrl at DEPTH=16 (instance a) and DEPTH=12 (instance b).
// Latency: inputs driven at the falling edge, combinational outputs sampled 1 ns later.
// Backpressure: registered outputs sampled at the next falling edge.
module tb_fifo_ptr_ctrl;

  logic ck;
  logic reset_n;
  int   n_assert;
  int   n_fail;

  fifo_ptr_ctrl_if #(.DEPTH(16)) a_if ();
  fifo_ptr_ctrl_if #(.DEPTH(12)) b_if ();

  fifo_ptr_ctrl #(.DEPTH(16)) dut_a (
    .ck      (ck),
    .reset_n (reset_n),
    .bus     (a_if.slave)
  );

  fifo_ptr_ctrl #(.DEPTH(12)) dut_b (
    .ck      (ck),
    .reset_n (reset_n),
    .bus     (b_if.slave)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic clr, input logic w, input logic r);
    a_if.clr_ptr = clr;
    a_if.wr_req  = w;
    a_if.rd_req  = r;
  endtask

  initial begin
    int mw, mr, mc, writes;
    logic we, re, movf;

    n_assert = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    set_a(1'b0, 1'b0, 1'b0);
    b_if.clr_ptr = 1'b0;
    b_if.wr_req  = 1'b0;
    b_if.rd_req  = 1'b0;

    @(negedge ck);
    @(negedge ck);
    reset_n = 1'b1;
    #1;
    chk("rst_wr_ptr", a_if.wr_ptr, 0);
    chk("rst_rd_ptr", a_if.rd_ptr, 0);
    chk("rst_count", a_if.count, 0);
    chk("rst_empty", a_if.empty, 1);
    chk("rst_aempty", a_if.almost_empty, 1);
    chk("rst_full", a_if.full, 0);
    chk("rst_afull", a_if.almost_full, 0);
    chk("rst_ovf", a_if.overflow, 0);
    chk("rst_unf", a_if.underflow, 0);
    chk("rst_b_empty", b_if.empty, 1);

    // 1: async reset in the middle of a cycle with count=5
    @(negedge ck);
    set_a(1'b0, 1'b1, 1'b0);
    repeat (5) @(negedge ck);
    set_a(1'b0, 1'b0, 1'b0);
    chk("t1_count5", a_if.count, 5);
    chk("t1_wr_ptr5", a_if.wr_ptr, 5);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_async_count", a_if.count, 0);
    chk("t1_async_wr_ptr", a_if.wr_ptr, 0);
    chk("t1_async_rd_ptr", a_if.rd_ptr, 0);
    chk("t1_async_empty", a_if.empty, 1);
    chk("t1_async_aempty", a_if.almost_empty, 1);
    @(negedge ck);
    reset_n = 1'b1;

    // 2: fill to 16, then one write too many
    for (int i = 1; i <= 16; i++) begin
      set_a(1'b0, 1'b1, 1'b0);
      #1 chk("t2_wr_en", a_if.wr_en, 1);
      @(negedge ck);
      chk("t2_count", a_if.count, i);
      chk("t2_wr_ptr", a_if.wr_ptr, i % 16);
      chk("t2_afull", a_if.almost_full, (i >= 14));
      chk("t2_full", a_if.full, (i == 16));
      chk("t2_empty", a_if.empty, 0);
    end
    #1 chk("t2_17th_wr_en", a_if.wr_en, 0);
    @(negedge ck);
    set_a(1'b0, 1'b0, 1'b0);
    chk("t2_17th_count", a_if.count, 16);
    chk("t2_17th_ovf", a_if.overflow, 1);
    chk("t2_17th_wr_ptr", a_if.wr_ptr, 0);

    // 3: drain from full, then one read too many
    for (int i = 1; i <= 16; i++) begin
      set_a(1'b0, 1'b0, 1'b1);
      #1 chk("t3_rd_en", a_if.rd_en, 1);
      @(negedge ck);
      chk("t3_count", a_if.count, 16 - i);
      chk("t3_rd_ptr", a_if.rd_ptr, i % 16);
      chk("t3_empty", a_if.empty, (i == 16));
      chk("t3_aempty", a_if.almost_empty, (i >= 14));
    end
    #1 chk("t3_extra_rd_en", a_if.rd_en, 0);
    @(negedge ck);
    set_a(1'b0, 1'b0, 1'b0);
    chk("t3_extra_unf", a_if.underflow, 1);
    chk("t3_extra_count", a_if.count, 0);

    // 5: simultaneous requests at count=7, at full, at empty
    set_a(1'b0, 1'b1, 1'b0);
    repeat (7) @(negedge ck);
    chk("t5_count7", a_if.count, 7);
    set_a(1'b0, 1'b1, 1'b1);
    #1;
    chk("t5_mid_wr_en", a_if.wr_en, 1);
    chk("t5_mid_rd_en", a_if.rd_en, 1);
    @(negedge ck);
    chk("t5_mid_count", a_if.count, 7);
    chk("t5_mid_wr_ptr", a_if.wr_ptr, 8);
    chk("t5_mid_rd_ptr", a_if.rd_ptr, 1);
    set_a(1'b0, 1'b1, 1'b0);
    repeat (9) @(negedge ck);
    chk("t5_full", a_if.full, 1);
    set_a(1'b0, 1'b1, 1'b1);
    #1;
    chk("t5_full_wr_en", a_if.wr_en, 0);
    chk("t5_full_rd_en", a_if.rd_en, 1);
    @(negedge ck);
    chk("t5_full_count", a_if.count, 15);
    chk("t5_full_wr_ptr", a_if.wr_ptr, 1);
    chk("t5_full_rd_ptr", a_if.rd_ptr, 2);
    set_a(1'b0, 1'b0, 1'b1);
    repeat (15) @(negedge ck);
    chk("t5_empty", a_if.empty, 1);
    set_a(1'b0, 1'b1, 1'b1);
    #1;
    chk("t5_empty_wr_en", a_if.wr_en, 1);
    chk("t5_empty_rd_en", a_if.rd_en, 0);
    @(negedge ck);
    chk("t5_empty_count", a_if.count, 1);
    chk("t5_empty_wr_ptr", a_if.wr_ptr, 2);
    chk("t5_empty_rd_ptr", a_if.rd_ptr, 1);

    // 6: clear beats a write at count=9 with overflow set
    set_a(1'b0, 1'b1, 1'b0);
    repeat (8) @(negedge ck);
    chk("t6_count9", a_if.count, 9);
    chk("t6_ovf_set", a_if.overflow, 1);
    set_a(1'b1, 1'b1, 1'b0);
    #1 chk("t6_wr_en", a_if.wr_en, 0);
    @(negedge ck);
    set_a(1'b0, 1'b0, 1'b0);
    chk("t6_wr_ptr", a_if.wr_ptr, 0);
    chk("t6_rd_ptr", a_if.rd_ptr, 0);
    chk("t6_count", a_if.count, 0);
    chk("t6_empty", a_if.empty, 1);
    chk("t6_ovf", a_if.overflow, 0);
    chk("t6_unf", a_if.underflow, 0);

    // 4: DEPTH=12 wrap, 30 accepted writes with a read every third cycle
    mw = 0; mr = 0; mc = 0; writes = 0; movf = 1'b0;
    for (int i = 0; i < 200 && writes < 30; i++) begin
      b_if.wr_req = 1'b1;
      b_if.rd_req = (i % 3 == 2);
      we = (mc != 12);
      re = b_if.rd_req && (mc != 0);
      if (mc == 12) movf = 1'b1;
      #1;
      chk("t4_wr_en", b_if.wr_en, we);
      chk("t4_rd_en", b_if.rd_en, re);
      if (we) begin
        mw = (mw == 11) ? 0 : mw + 1;
        mc++;
        writes++;
      end
      if (re) begin
        mr = (mr == 11) ? 0 : mr + 1;
        mc--;
      end
      @(negedge ck);
      chk("t4_wr_ptr", b_if.wr_ptr, mw);
      chk("t4_rd_ptr", b_if.rd_ptr, mr);
      chk("t4_count", b_if.count, mc);
      chk("t4_full", b_if.full, (mc == 12));
      chk("t4_afull", b_if.almost_full, (mc >= 10));
      chk("t4_aempty", b_if.almost_empty, (mc <= 2));
      chk("t4_invariant", b_if.wr_ptr, (int'(b_if.rd_ptr) + int'(b_if.count)) % 12);
    end
    b_if.wr_req = 1'b0;
    b_if.rd_req = 1'b0;
    chk("t4_writes_done", writes, 30);
    chk("t4_ovf", b_if.overflow, movf);
    chk("t4_unf", b_if.underflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
